// File: rtl/ccff_prog_ctrl_if.sv
// rtl/ccff_prog_ctrl_if.sv - bitstream word stream between word source and programming controller
// Signals:
//   word_data  : bitstream word, MSB is shifted into the chain first
//   word_valid : source has a word on word_data
//   word_ready : controller takes the word in this cycle
// Modports: master = word source, slave = ccff_prog_ctrl.
interface ccff_prog_ctrl_if #(
  parameter int WORD_WIDTH = 32
);
  logic [WORD_WIDTH-1:0] word_data;
  logic                  word_valid;
  logic                  word_ready;

  modport master (
    output word_data,
    output word_valid,
    input  word_ready
  );

  modport slave (
    input  word_data,
    input  word_valid,
    output word_ready
  );
endinterface

// File: rtl/ccff_prog_ctrl.sv
// rtl/ccff_prog_ctrl.sv - configuration-chain programming controller with marker self-test
// Serialises bitstream words MSB-first onto ccff_head and gates the fabric prog clock
// through fabric_prog_en, or pushes a single '1' marker through the chain and checks
// that it comes back on ccff_tail after exactly BITSTREAM_SIZE shifts.
// Ports:
//   prog_clk, pReset     : clock (rising edge) and asynchronous active-low reset
//   start, test_mode     : start pulse, mode sampled with start (1 = self-test)
//   abort                : return to IDLE on the next edge
//   src                  : word stream (slave side)
//   ccff_head, ccff_tail : serial data into / out of the chain
//   fabric_prog_en       : prog clock enable, registered together with ccff_head
//   busy, done, error    : status
//   bit_count            : bits shifted since the last start (saturating)
module ccff_prog_ctrl #(
  parameter int BITSTREAM_SIZE = 29696,
  parameter int WORD_WIDTH     = 32,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                 prog_clk,
  input  logic                 pReset,
  input  logic                 start,
  input  logic                 test_mode,
  input  logic                 abort,
  ccff_prog_ctrl_if.slave      src,
  output logic                 ccff_head,
  input  logic                 ccff_tail,
  output logic                 fabric_prog_en,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [CNT_WIDTH-1:0] bit_count
);

  localparam int WB_W = $clog2(WORD_WIDTH + 1);

  localparam logic [CNT_WIDTH-1:0] N_BITS    = CNT_WIDTH'(BITSTREAM_SIZE);
  localparam logic [CNT_WIDTH-1:0] N_PLUS1   = CNT_WIDTH'(BITSTREAM_SIZE + 1);
  localparam logic [CNT_WIDTH-1:0] N_PLUS2   = CNT_WIDTH'(BITSTREAM_SIZE + 2);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = CNT_WIDTH'(BITSTREAM_SIZE + 3);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] WORD_BITS = CNT_WIDTH'(WORD_WIDTH);
  localparam logic [WB_W-1:0]      WB_ONE    = WB_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_TEST,
    ST_DONE,
    ST_FAIL
  } state_t;

  state_t                 state_q, state_d;
  logic [WORD_WIDTH-1:0]  shift_q, shift_d;
  logic [WB_W-1:0]        wbits_q, wbits_d;   // bits of the current word still to present
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d, cnt_inc, take_base;
  logic                   head_q, head_d;
  logic                   en_q, en_d;
  logic                   done_q, done_d;
  logic                   error_q, error_d;
  logic                   ready;
  logic                   take;

  // Number of bits to use from a word when done_bits have already been shifted;
  // the final word is truncated so the chain receives exactly BITSTREAM_SIZE bits.
  function automatic logic [WB_W-1:0] word_len(input logic [CNT_WIDTH-1:0] done_bits);
    logic [CNT_WIDTH-1:0] left;
    left = N_BITS - done_bits;
    if (left >= WORD_BITS) return WB_W'(WORD_WIDTH);
    else                   return WB_W'(left);
  endfunction

  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      wbits_q <= '0;
      cnt_q   <= '0;
      head_q  <= 1'b0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      wbits_q <= wbits_d;
      cnt_q   <= cnt_d;
      head_q  <= head_d;
      en_q    <= en_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    wbits_d   = wbits_q;
    cnt_d     = cnt_q;
    head_d    = 1'b0;
    en_d      = 1'b0;
    done_d    = done_q;
    error_d   = error_q;
    ready     = 1'b0;
    take_base = cnt_q;
    cnt_inc   = (cnt_q >= CNT_MAX) ? CNT_MAX : cnt_q + CNT_ONE;

    if (abort) begin
      state_d = ST_IDLE;
      done_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE, ST_FAIL: begin
          if (start) begin
            cnt_d   = '0;
            done_d  = 1'b0;
            error_d = 1'b0;
            if (test_mode) begin
              // Shift cycle 0 of the self-test is the cycle right after start.
              state_d = ST_TEST;
              head_d  = 1'b1;
              en_d    = 1'b1;
            end else begin
              state_d = ST_LOAD;
            end
          end
        end

        ST_LOAD: begin
          ready = 1'b1;
        end

        ST_SHIFT: begin
          cnt_d = cnt_inc;
          if (wbits_q == WB_ONE) begin
            if (cnt_inc >= N_BITS) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              // Last bit of the word: a waiting word continues the stream with no bubble.
              ready     = 1'b1;
              take_base = cnt_inc;
              if (!src.word_valid) state_d = ST_LOAD;
            end
          end else begin
            head_d  = shift_q[WORD_WIDTH-1];
            shift_d = {shift_q[WORD_WIDTH-2:0], 1'b0};
            wbits_d = wbits_q - WB_ONE;
            en_d    = 1'b1;
          end
        end

        ST_TEST: begin
          cnt_d = cnt_inc;
          en_d  = 1'b1;
          // The marker must be seen exactly at cycle N and nowhere in the two following cycles.
          if ((cnt_q == N_BITS && !ccff_tail) ||
              ((cnt_q == N_PLUS1 || cnt_q == N_PLUS2) && ccff_tail)) begin
            state_d = ST_FAIL;
            error_d = 1'b1;
            en_d    = 1'b0;
          end else if (cnt_q == N_PLUS2) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            en_d    = 1'b0;
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end

    take = ready && src.word_valid;
    if (take) begin
      state_d = ST_SHIFT;
      head_d  = src.word_data[WORD_WIDTH-1];
      shift_d = {src.word_data[WORD_WIDTH-2:0], 1'b0};
      wbits_d = word_len(take_base);
      en_d    = 1'b1;
    end
  end

  assign src.word_ready   = ready;
  assign ccff_head        = head_q;
  assign fabric_prog_en   = en_q;
  assign busy             = (state_q == ST_LOAD) || (state_q == ST_SHIFT) || (state_q == ST_TEST);
  assign done             = done_q;
  assign error            = error_q;
  assign bit_count        = cnt_q;

endmodule

// File: tb/tb_ccff_prog_ctrl.sv
// tb/tb_ccff_prog_ctrl.sv - self-checking bench for ccff_prog_ctrl
module tb_ccff_prog_ctrl;

  logic        prog_clk;
  logic        pReset;
  logic        start64, start40;
  logic        test_mode;
  logic        abort;
  logic [31:0] src_data;
  logic        src_valid;
  logic        tail;

  logic        head64, en64, busy64, done64, error64;
  logic        head40, en40, busy40, done40, error40;
  logic [15:0] cnt64, cnt40;

  ccff_prog_ctrl_if #(.WORD_WIDTH(32)) if64 ();
  ccff_prog_ctrl_if #(.WORD_WIDTH(32)) if40 ();

  assign if64.word_data  = src_data;
  assign if64.word_valid = src_valid;
  assign if40.word_data  = src_data;
  assign if40.word_valid = src_valid;

  ccff_prog_ctrl #(.BITSTREAM_SIZE(64), .WORD_WIDTH(32), .CNT_WIDTH(16)) dut64 (
    .prog_clk(prog_clk), .pReset(pReset), .start(start64), .test_mode(test_mode),
    .abort(abort), .src(if64), .ccff_head(head64), .ccff_tail(tail),
    .fabric_prog_en(en64), .busy(busy64), .done(done64), .error(error64), .bit_count(cnt64)
  );

  ccff_prog_ctrl #(.BITSTREAM_SIZE(40), .WORD_WIDTH(32), .CNT_WIDTH(16)) dut40 (
    .prog_clk(prog_clk), .pReset(pReset), .start(start40), .test_mode(test_mode),
    .abort(abort), .src(if40), .ccff_head(head40), .ccff_tail(tail),
    .fabric_prog_en(en40), .busy(busy40), .done(done40), .error(error40), .bit_count(cnt40)
  );

  initial prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  // Observed DUT selected by sel (0 = 64-bit chain, 1 = 40-bit chain).
  logic        sel;
  logic        m_head, m_en, m_busy, m_ready, m_done, m_error;
  logic [15:0] m_cnt;
  assign m_head  = sel ? head40  : head64;
  assign m_en    = sel ? en40    : en64;
  assign m_busy  = sel ? busy40  : busy64;
  assign m_ready = sel ? if40.word_ready : if64.word_ready;
  assign m_done  = sel ? done40  : done64;
  assign m_error = sel ? error40 : error64;
  assign m_cnt   = sel ? cnt40   : cnt64;

  // Chain model: only enabled edges advance it.
  logic [63:0] chain;
  int          chain_len;
  always @(posedge prog_clk) begin
    if (!pReset)   chain <= '0;
    else if (m_en) chain <= {chain[62:0], m_head};
  end
  assign tail = (chain_len == 63) ? chain[62] : chain[63];

  int   n_cmp = 0;
  int   n_bad = 0;
  logic sb[$];
  int   en_cnt, stall_cnt, hs_cnt, pushed, nbits;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge prog_clk) begin
    if (pReset) begin
      if (m_ready && src_valid) hs_cnt++;
      if (m_en) begin
        en_cnt++;
        check("head_bit_avail", (sb.size() != 0), 1'b1);
        if (sb.size() != 0) check("head_bit", m_head, sb.pop_front());
      end else if (m_busy) begin
        stall_cnt++;
        check("head_stall", m_head, 1'b0);
      end
    end
  end

  typedef struct {
    logic        sel;
    logic        tmode;
    logic [31:0] w0;
    logic [31:0] w1;
    int          gap;
    int          chain_len;
    logic        exp_done;
    logic        exp_error;
    int          exp_en;
    int          exp_cnt;
    int          exp_stall;
    int          exp_hs;
  } vec_t;

  vec_t vecs[6];

  task automatic push_bits(input logic [31:0] w);
    int take;
    take = (nbits - pushed < 32) ? nbits - pushed : 32;
    for (int i = 0; i < take; i++) sb.push_back(w[31-i]);
    pushed += take;
  endtask

  task automatic pulse_start();
    @(posedge prog_clk); #1;
    if (sel) start40 = 1'b1; else start64 = 1'b1;
    @(posedge prog_clk); #1;
    start40 = 1'b0;
    start64 = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    do begin @(negedge prog_clk); n++; end while (!m_ready && n < 200);
    check(name, m_ready, 1'b1);
  endtask

  task automatic feed_word(input logic [31:0] w, input int gap);
    push_bits(w);
    if (gap > 0) begin
      src_valid = 1'b0;
      wait_ready("gap_ready");
      repeat (gap) @(posedge prog_clk);
      #1;
    end
    src_data  = w;
    src_valid = 1'b1;
    wait_ready("handshake");
    @(posedge prog_clk); #1;
    src_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin @(negedge prog_clk); n++; end while (m_busy && n < 400);
    check("busy_drop", m_busy, 1'b0);
  endtask

  task automatic run_vec(input vec_t v);
    sel       = v.sel;
    chain_len = v.chain_len;
    nbits     = v.sel ? 40 : 64;
    sb.delete();
    en_cnt    = 0;
    stall_cnt = 0;
    hs_cnt    = 0;
    pushed    = 0;
    test_mode = v.tmode;
    if (v.tmode) begin
      sb.push_back(1'b1);
      for (int i = 1; i < v.exp_en; i++) sb.push_back(1'b0);
    end
    pulse_start();
    if (!v.tmode) begin
      feed_word(v.w0, 0);
      feed_word(v.w1, v.gap);
      // A further word stays on offer; it must never be taken.
      src_data  = $urandom;
      src_valid = 1'b1;
    end
    wait_idle();
    check("done",      m_done,    v.exp_done);
    check("error",     m_error,   v.exp_error);
    check("bit_count", m_cnt,     v.exp_cnt);
    check("en_cycles", en_cnt,    v.exp_en);
    check("stall",     stall_cnt, v.exp_stall);
    check("handshake", hs_cnt,    v.exp_hs);
    check("sb_left",   sb.size(), 0);
    src_valid = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_head"},  head64, 1'b0);
    check({tag, "_en"},    en64,   1'b0);
    check({tag, "_busy"},  busy64, 1'b0);
    check({tag, "_done"},  done64, 1'b0);
    check({tag, "_ready"}, if64.word_ready, 1'b0);
  endtask

  initial begin
    int n;
    vecs[0] = '{1'b0, 1'b0, 32'hA5A5_0001, 32'h8000_00FF, 0, 64, 1'b1, 1'b0, 64, 64, 1, 2};
    vecs[1] = '{1'b0, 1'b0, 32'hA5A5_0001, 32'h8000_00FF, 5, 64, 1'b1, 1'b0, 64, 64, 6, 2};
    vecs[2] = '{1'b0, 1'b0, 32'h1234_5678, 32'hDEAD_BEEF, 2, 64, 1'b1, 1'b0, 64, 64, 3, 2};
    vecs[3] = '{1'b1, 1'b0, 32'h0F0F_1234, 32'hA5FF_FFFF, 0, 64, 1'b1, 1'b0, 40, 40, 1, 2};
    vecs[4] = '{1'b0, 1'b1, 32'h0,         32'h0,         0, 64, 1'b1, 1'b0, 67, 67, 0, 0};
    vecs[5] = '{1'b0, 1'b1, 32'h0,         32'h0,         0, 63, 1'b0, 1'b1, 65, 65, 0, 0};

    pReset = 1'b0; start64 = 1'b0; start40 = 1'b0; test_mode = 1'b0; abort = 1'b0;
    src_data = '0; src_valid = 1'b0; sel = 1'b0; chain_len = 64;
    en_cnt = 0; stall_cnt = 0; hs_cnt = 0; pushed = 0; nbits = 64;

    repeat (3) @(posedge prog_clk);
    @(negedge prog_clk);
    check_idle_outputs("rst");
    check("rst_error", error64, 1'b0);
    check("rst_cnt",   cnt64,   16'd0);
    check("rst_busy40", busy40, 1'b0);
    check("rst_cnt40",  cnt40,  16'd0);
    pReset = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Abort out of FAIL keeps error but leaves IDLE.
    sel = 1'b0;
    @(posedge prog_clk); #1 abort = 1'b1;
    @(posedge prog_clk); #1 abort = 1'b0;
    @(negedge prog_clk);
    check("abort_fail_error", error64, 1'b1);
    check_idle_outputs("abort_fail");

    // Abort at bit 20 of a load.
    sb.delete(); pushed = 0; nbits = 64; en_cnt = 0; test_mode = 1'b0;
    pulse_start();
    push_bits(32'hF0F0_3C3C);
    src_data = 32'hF0F0_3C3C; src_valid = 1'b1;
    n = 0;
    do begin @(negedge prog_clk); n++; end while (en_cnt < 20 && n < 200);
    check("abort_reach20", (en_cnt >= 20), 1'b1);
    @(posedge prog_clk); #1 abort = 1'b1;
    @(posedge prog_clk); #1 abort = 1'b0; src_valid = 1'b0;
    @(negedge prog_clk);
    check_idle_outputs("abort_load");

    // Abort in the same cycle a word is offered: the word is not taken.
    pulse_start();
    src_data = 32'hFFFF_FFFF; src_valid = 1'b1; abort = 1'b1;
    @(posedge prog_clk); #1 abort = 1'b0; src_valid = 1'b0;
    @(negedge prog_clk);
    check_idle_outputs("abort_offer");

    // Asynchronous reset in the middle of a self-test.
    sb.delete(); sb.push_back(1'b1);
    for (int i = 0; i < 100; i++) sb.push_back(1'b0);
    en_cnt = 0; test_mode = 1'b1; chain_len = 64;
    pulse_start();
    n = 0;
    do begin @(negedge prog_clk); n++; end while (en_cnt < 30 && n < 200);
    #2 pReset = 1'b0;
    #1 check("rst_async_en", en64, 1'b0);
    @(negedge prog_clk);
    pReset = 1'b1;
    @(negedge prog_clk);
    check_idle_outputs("rst_mid");
    check("rst_mid_error", error64, 1'b0);
    check("rst_mid_cnt",   cnt64,   16'd0);

    // A fresh load completes normally after the reset.
    run_vec(vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
